// File: rtl/cpu_clk_pkg.sv
// Shared encodings for the CPU clock run/halt/step controller.
package cpu_clk_pkg;

    localparam int unsigned STEP_W_DEF = 16;

    localparam logic [1:0] CMD_NOP  = 2'b00;
    localparam logic [1:0] CMD_RUN  = 2'b01;
    localparam logic [1:0] CMD_HALT = 2'b10;
    localparam logic [1:0] CMD_STEP = 2'b11;

    typedef enum logic [1:0] {
        ST_HALTED,
        ST_RUN,
        ST_STEP
    } state_e;

endpackage

// File: rtl/clk_tick_gen.sv
// Programmable divider: emits a one-cycle tick every div_q+1 clocks and a toggling clk_cpu level.
// A new divide value applies immediately when halted, otherwise at the next tick.
module clk_tick_gen #(
    parameter int unsigned DIV_W       = 8,
    parameter int unsigned DEFAULT_DIV = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             halted,
    output logic             tick,
    output logic             clk_cpu
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             clk_cpu_q, clk_cpu_d;

    assign tick    = (cnt_q == div_q);
    assign clk_cpu = clk_cpu_q;

    always_comb begin
        cnt_d      = tick ? '0 : cnt_q + 1'b1;
        div_d      = div_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        clk_cpu_d  = clk_cpu_q ^ tick;
        if (tick && pend_vld_q) begin
            div_d      = pend_q;
            pend_vld_d = 1'b0;
        end
        // A write while halted wins over any pending value and restarts the period.
        if (cfg_we) begin
            if (halted) begin
                div_d      = cfg_div;
                cnt_d      = '0;
                pend_vld_d = 1'b0;
            end else begin
                pend_d     = cfg_div;
                pend_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            div_q      <= DIV_W'(DEFAULT_DIV);
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            clk_cpu_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            clk_cpu_q  <= clk_cpu_d;
        end
    end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// Run/halt/single-step controller gating the CPU clock enable from a programmable divider.
// Define CPU_CLK_CTRL_BKPT_EN to add the PC breakpoint comparator.
module cpu_clk_ctrl
    import cpu_clk_pkg::*;
#(
    parameter int unsigned DIV_W       = 8,
    parameter int unsigned DEFAULT_DIV = 9,
    parameter int unsigned STEP_W      = STEP_W_DEF,
    parameter int unsigned PC_W        = 32,
    parameter bit          RESET_RUN   = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic [PC_W-1:0]   cpu_pc,
`ifdef CPU_CLK_CTRL_BKPT_EN
    input  logic              bp_en,
    input  logic [PC_W-1:0]   bp_addr,
    output logic              bp_hit,
`endif
    output logic              cpu_ce,
    output logic              clk_cpu,
    output logic              halted,
    output logic [STEP_W-1:0] steps_left
);

    localparam state_e ST_RESET = RESET_RUN ? ST_RUN : ST_HALTED;

    state_e            state_q, state_d;
    logic [STEP_W-1:0] steps_q, steps_d;
    logic              ce_q, ce_d;
    logic              tick;
    logic              cmd_acc;
    logic              bp_stop;

    assign halted     = (state_q == ST_HALTED);
    assign cpu_ce     = ce_q;
    assign steps_left = steps_q;
    assign cmd_ready  = (state_q != ST_STEP) || (cmd_op == CMD_HALT);
    assign cmd_acc    = cmd_valid && cmd_ready;

    clk_tick_gen #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .cfg_we  (cfg_we),
        .cfg_div (cfg_div),
        .halted  (halted),
        .tick    (tick),
        .clk_cpu (clk_cpu)
    );

`ifdef CPU_CLK_CTRL_BKPT_EN
    logic bp_hit_q, bp_hit_d;
    logic skip_q, skip_d;
    logic go_cmd;

    // Exempting the first tick after a start lets the CPU step off the breakpoint address.
    assign go_cmd  = cmd_acc && ((cmd_op == CMD_RUN) || (cmd_op == CMD_STEP));
    assign bp_stop = tick && !halted && bp_en && (cpu_pc == bp_addr) && !skip_q;
    assign bp_hit  = bp_hit_q;

    always_comb begin
        bp_hit_d = bp_hit_q;
        skip_d   = skip_q;
        if (go_cmd) bp_hit_d = 1'b0;
        if (bp_stop) bp_hit_d = 1'b1;
        if (go_cmd && halted) skip_d = (cpu_pc == bp_addr);
        else if (tick) skip_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bp_hit_q <= 1'b0;
            skip_q   <= 1'b0;
        end else begin
            bp_hit_q <= bp_hit_d;
            skip_q   <= skip_d;
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^cpu_pc;
    assign bp_stop   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        steps_d = steps_q;
        ce_d    = 1'b0;
        unique case (state_q)
            ST_HALTED: begin
                if (cmd_acc && cmd_op == CMD_RUN) begin
                    state_d = ST_RUN;
                end else if (cmd_acc && cmd_op == CMD_STEP) begin
                    state_d = ST_STEP;
                    steps_d = (cmd_steps == '0) ? STEP_W'(1) : cmd_steps;
                end
            end
            ST_RUN: begin
                if (cmd_acc && (cmd_op == CMD_HALT || cmd_op == CMD_STEP)) begin
                    state_d = ST_HALTED;
                end else if (bp_stop) begin
                    state_d = ST_HALTED;
                end else begin
                    ce_d = tick;
                end
            end
            ST_STEP: begin
                // Only HALT can be accepted here.
                if (cmd_acc || bp_stop) begin
                    state_d = ST_HALTED;
                    steps_d = '0;
                end else if (tick) begin
                    ce_d    = 1'b1;
                    steps_d = steps_q - 1'b1;
                    if (steps_q == STEP_W'(1)) state_d = ST_HALTED;
                end
            end
            default: begin
                state_d = ST_HALTED;
                steps_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RESET;
            steps_q <= '0;
            ce_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            steps_q <= steps_d;
            ce_q    <= ce_d;
        end
    end

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Self-checking bench for cpu_clk_ctrl: directed scenarios plus randomized traffic against a
// cycle-count reference model.
module tb_cpu_clk_ctrl;

    localparam int unsigned DIV_W  = 8;
    localparam int unsigned STEP_W = 16;
    localparam int unsigned PC_W   = 32;
    localparam int M_HALT = 0;
    localparam int M_RUN  = 1;
    localparam int M_STEP = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_we = 1'b0;
    logic [DIV_W-1:0]  cfg_div = '0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = 2'd0;
    logic [STEP_W-1:0] cmd_steps = '0;
    logic [PC_W-1:0]   cpu_pc = '0;
    logic              cpu_ce;
    logic              clk_cpu;
    logic              halted;
    logic [STEP_W-1:0] steps_left;
`ifdef CPU_CLK_CTRL_BKPT_EN
    logic              bp_en = 1'b0;
    logic [PC_W-1:0]   bp_addr = '0;
    logic              bp_hit;
`endif

    always #5 clk = ~clk;

    cpu_clk_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_div    (cfg_div),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_steps  (cmd_steps),
        .cpu_pc     (cpu_pc),
`ifdef CPU_CLK_CTRL_BKPT_EN
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .bp_hit     (bp_hit),
`endif
        .cpu_ce     (cpu_ce),
        .clk_cpu    (clk_cpu),
        .halted     (halted),
        .steps_left (steps_left)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: divider expressed as the edge index where the period last restarted.
    int m_mode, m_steps, m_div, m_pend, m_base, cyc;
    bit m_ce, m_clk_cpu, m_on;

    task automatic model_reset();
        m_mode = M_HALT; m_steps = 0; m_div = 9; m_pend = -1;
        m_base = cyc; m_ce = 0; m_clk_cpu = 0;
    endtask

    task automatic model_edge();
        bit tick, acc;
        int old_mode;
        tick = ((cyc - m_base) == m_div);
        acc = cmd_valid && ((m_mode != M_STEP) || (cmd_op == 2'd2));
        old_mode = m_mode;
        m_ce = 0;
        if (m_mode == M_HALT) begin
            if (acc && cmd_op == 2'd1) m_mode = M_RUN;
            else if (acc && cmd_op == 2'd3) begin
                m_mode = M_STEP;
                m_steps = (cmd_steps == 0) ? 1 : int'(cmd_steps);
            end
        end else if (m_mode == M_RUN) begin
            if (acc && cmd_op >= 2'd2) m_mode = M_HALT;
            else m_ce = tick;
        end else begin
            if (acc) begin
                m_mode = M_HALT; m_steps = 0;
            end else if (tick) begin
                m_ce = 1; m_steps--;
                if (m_steps == 0) m_mode = M_HALT;
            end
        end
        if (tick) begin
            m_base = cyc + 1;
            m_clk_cpu = !m_clk_cpu;
            if (m_pend >= 0) begin m_div = m_pend; m_pend = -1; end
        end
        if (cfg_we) begin
            if (old_mode == M_HALT) begin
                m_div = int'(cfg_div); m_base = cyc + 1; m_pend = -1;
            end else m_pend = int'(cfg_div);
        end
        cyc++;
    endtask

    task automatic step();
        #1;
        if (m_on) check_eq("cmd_ready", cmd_ready, (m_mode != M_STEP) || (cmd_op == 2'd2));
        @(posedge clk); #1;
        model_edge();
        if (m_on) begin
            check_eq("cpu_ce", cpu_ce, m_ce);
            check_eq("clk_cpu", clk_cpu, m_clk_cpu);
            check_eq("halted", halted, m_mode == M_HALT);
            check_eq("steps_left", 32'(steps_left), m_steps);
        end
    endtask

    task automatic send(input logic [1:0] op, input int steps);
        cmd_valid = 1'b1; cmd_op = op; cmd_steps = STEP_W'(steps);
        step();
        cmd_valid = 1'b0; cmd_op = 2'd0;
    endtask

    task automatic write_div(input int d);
        cfg_we = 1'b1; cfg_div = DIV_W'(d);
        step();
        cfg_we = 1'b0;
    endtask

    task automatic run_cycles(input int n, output int pulses, output int toggles,
                              output int min_gap, output int max_gap, output int last_gap);
        int last;
        logic prev;
        last = -1; pulses = 0; toggles = 0; min_gap = 1 << 30; max_gap = 0; last_gap = 0;
        prev = clk_cpu;
        for (int i = 0; i < n; i++) begin
            step();
            if (clk_cpu != prev) toggles++;
            prev = clk_cpu;
            if (cpu_ce) begin
                pulses++;
                if (last >= 0) begin
                    last_gap = i - last;
                    if (last_gap < min_gap) min_gap = last_gap;
                    if (last_gap > max_gap) max_gap = last_gap;
                end
                last = i;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_op = 2'd0; cfg_we = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int p, t, mn, mx, lg, cnt;
        cyc = 0; m_on = 1;
        #2;
        do_reset();
        check_eq("rst_halted", halted, 1);
        check_eq("rst_cpu_ce", cpu_ce, 0);
        check_eq("rst_clk_cpu", clk_cpu, 0);
        check_eq("rst_steps", 32'(steps_left), 0);
        check_eq("rst_ready", cmd_ready, 1);
        run_cycles(100, p, t, mn, mx, lg);
        check_eq("halt_no_pulse", p, 0);
        check_eq("clk_cpu_toggles", t, 10);

        // RUN at div 9, then HALT
        send(2'd1, 0);
        run_cycles(50, p, t, mn, mx, lg);
        check_eq("run_min_gap", mn, 10);
        check_eq("run_max_gap", mx, 10);
        send(2'd2, 0);
        check_eq("halt_next", halted, 1);
        run_cycles(30, p, t, mn, mx, lg);
        check_eq("after_halt_pulses", p, 0);

        // STEP 3 with a RUN request held off
        send(2'd3, 3);
        cmd_op = 2'd1;
        #1 check_eq("ready_in_step", cmd_ready, 0);
        run_cycles(40, p, t, mn, mx, lg);
        cmd_op = 2'd0;
        check_eq("step3_pulses", p, 3);
        check_eq("step3_gap", mx, 10);
        check_eq("step3_halted", halted, 1);
        check_eq("step3_left", 32'(steps_left), 0);
        send(2'd3, 0);
        run_cycles(25, p, t, mn, mx, lg);
        check_eq("step0_pulses", p, 1);

        // Divider change while running, then while halted
        send(2'd1, 0);
        run_cycles(5, p, t, mn, mx, lg);
        write_div(3);
        run_cycles(40, p, t, mn, mx, lg);
        check_eq("newdiv_min_gap", mn, 4);
        check_eq("newdiv_last_gap", lg, 4);
        send(2'd2, 0);
        write_div(0);
        send(2'd1, 0);
        run_cycles(10, p, t, mn, mx, lg);
        check_eq("div0_pulses", p, 10);
        check_eq("div0_gap", mx, 1);
        send(2'd2, 0);
        write_div(9);

        // STEP 5 aborted after two pulses
        send(2'd3, 5);
        cnt = 0;
        for (int i = 0; i < 100 && cnt < 2; i++) begin
            step();
            if (cpu_ce) cnt++;
        end
        check_eq("step5_reach2", cnt, 2);
        send(2'd2, 0);
        check_eq("abort_halted", halted, 1);
        check_eq("abort_left", 32'(steps_left), 0);
        run_cycles(30, p, t, mn, mx, lg);
        check_eq("abort_no_more", p, 0);

        // Asynchronous reset mid-RUN
        send(2'd1, 0);
        run_cycles(15, p, t, mn, mx, lg);
        #1 rst_n = 1'b0;
        #1;
        check_eq("arst_halted", halted, 1);
        check_eq("arst_cpu_ce", cpu_ce, 0);
        check_eq("arst_clk_cpu", clk_cpu, 0);
        check_eq("arst_ready", cmd_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cmd_valid = ($urandom_range(0, 3) == 0);
            cmd_op    = 2'($urandom_range(0, 3));
            cmd_steps = STEP_W'($urandom_range(0, 4));
            cfg_we    = ($urandom_range(0, 19) == 0);
            cfg_div   = DIV_W'($urandom_range(0, 5));
            step();
        end
        cmd_valid = 1'b0; cfg_we = 1'b0; cmd_op = 2'd0;

`ifdef CPU_CLK_CTRL_BKPT_EN
        do_reset();
        m_on = 0;
        bp_en = 1'b1; bp_addr = 32'h40; cpu_pc = 32'h10;
        send(2'd1, 0);
        run_cycles(15, p, t, mn, mx, lg);
        cpu_pc = 32'h40;
        run_cycles(30, p, t, mn, mx, lg);
        check_eq("bp_no_pulse", p, 0);
        check_eq("bp_halted", halted, 1);
        check_eq("bp_hit_set", bp_hit, 1);
        send(2'd3, 1);
        check_eq("bp_hit_clear", bp_hit, 0);
        run_cycles(25, p, t, mn, mx, lg);
        check_eq("bp_step_pulses", p, 1);
        check_eq("bp_step_halted", halted, 1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
